// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Runs the host request sequence (clock
// inhibit, start bit, release clock), shifts a command byte out on the
// device-generated clock, checks the device ACK, and reports done/err.
// Pad inputs are synchronized and glitch-filtered before any protocol use.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int SETUP_CYCLES   = 20,
  parameter int FILTER_LEN     = 19,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       done,
  output logic       err
);
  localparam int PW = $clog2(INHIBIT_CYCLES + SETUP_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, ACK, RELEASE} state_t;
  state_t state, state_nxt;

  // bit 0 = clock line, bit 1 = data line
  logic [1:0]         raw, s1, s2, filt;
  logic [1:0][FW-1:0] fcnt;
  logic               kclk_f, kdata_f, kclk_q, fall;

  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    n;
  logic [7:0]    tx_byte;
  logic          parity;
  logic          data_oe_r;
  logic          in_frame, timeout;

  assign raw = {kdata_i, kclk_i};

  // Two-flop synchronizers; reset to the idle (high) bus level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Filter: a line only changes after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        fcnt[g] <= '0;
        filt[g] <= 1'b1;
      end else if (s2[g] == filt[g]) begin
        fcnt[g] <= '0;
      end else if (fcnt[g] == FW'(FILTER_LEN - 1)) begin
        fcnt[g] <= '0;
        filt[g] <= s2[g];
      end else begin
        fcnt[g] <= fcnt[g] + FW'(1);
      end
    end
  end

  assign kclk_f  = filt[0];
  assign kdata_f = filt[1];
  assign fall    = kclk_q & ~kclk_f;

  // Previous filtered clock for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) kclk_q <= 1'b1;
    else        kclk_q <= kclk_f;
  end

  // The timer holds (cycles since last fall) - 1, so hitting the last value
  // means TIMEOUT_CYCLES cycles have elapsed without a device clock edge.
  assign in_frame = (state == DATA) || (state == ACK) || (state == RELEASE);
  assign timeout  = in_frame && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and outputs; pad drives come straight from state so a reset
  // or abort releases both lines immediately.
  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    kclk_oe   = 1'b0;
    kdata_oe  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) state_nxt = INHIBIT;
      end
      INHIBIT: begin
        kclk_oe = 1'b1;
        if (pcnt == PW'(INHIBIT_CYCLES - 1)) state_nxt = REQ;
      end
      REQ: begin
        kclk_oe  = 1'b1;
        kdata_oe = 1'b1;
        if (pcnt == PW'(SETUP_CYCLES - 1)) state_nxt = DATA;
      end
      DATA: begin
        if (timeout) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end else begin
          kdata_oe = data_oe_r;
          if (fall && n == 4'd9) state_nxt = ACK;
        end
      end
      ACK: begin
        if (timeout) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end else if (fall) begin
          if (!kdata_f) begin
            state_nxt = RELEASE;
          end else begin
            err       = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      RELEASE: begin
        if (timeout) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end else if (kclk_f && kdata_f) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: phase counter, byte latch, bit counter, data drive, timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt      <= '0;
      tcnt      <= '0;
      n         <= '0;
      tx_byte   <= '0;
      parity    <= 1'b0;
      data_oe_r <= 1'b0;
    end else begin
      if ((state == INHIBIT || state == REQ) && state_nxt == state)
        pcnt <= pcnt + PW'(1);
      else
        pcnt <= '0;

      if (state == IDLE && tx_valid) begin
        tx_byte <= tx_data;
        parity  <= ~^tx_data;
      end

      if (state == REQ && state_nxt == DATA) begin
        n         <= '0;
        data_oe_r <= 1'b1;
      end else if (state == DATA && fall) begin
        n <= n + 4'd1;
        // n is the edge count before this fall, so n also indexes the next bit.
        if (n < 4'd8)       data_oe_r <= ~tx_byte[n[2:0]];
        else if (n == 4'd8) data_oe_r <= ~parity;
        else                data_oe_r <= 1'b0;
      end

      if (in_frame && !fall && state_nxt == state) tcnt <= tcnt + TW'(1);
      else                                         tcnt <= '0;
    end
  end
endmodule
